float_accumulate_ctrl: RTL
==========================

# float_accumulate_ctrl

Issuing-side controller for the multi-cycle float adder. It accepts a stream of IEEE-754 single-precision operands over a valid/ready handshake and folds them into a running sum. For each operand it drives one `Op1`/`Op2`/`InputValid` transaction to the adder and waits for the adder's one-cycle `ResultValid` pulse. When the stream's last element has been folded in, it presents the total and the element count on a valid/ready result port.

## Interface
Parameters:
- `COUNT_W`, 16: width of the element counter.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles, counted while waiting on the adder.

Ports:
- `Clock` in 1: sole clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `InData` in float: operand from the stream.
- `InValid` in 1: `InData`/`InLast` valid.
- `InLast` in 1: marks the final element of the stream.
- `InReady` out 1: controller can accept an element this cycle.
- `Op1` out float: adder operand, the running accumulator.
- `Op2` out float: adder operand, the new element.
- `InputValid` out 1: one-cycle start pulse to the adder.
- `Result` in float: adder sum.
- `ResultValid` in 1: adder sum valid (one-cycle pulse).
- `Sum` out float: final total.
- `SumCount` out COUNT_W: number of elements folded into `Sum`.
- `SumValid` out 1: `Sum`/`SumCount` valid.
- `SumReady` in 1: consumer accepts the result.
- `Error` out 1: sticky watchdog flag.

## Operation
- Reset values: `InReady`=0, `InputValid`=0, `Op1`=`Op2`=0, `Sum`=0, `SumCount`=0, `SumValid`=0, `Error`=0. The state is IDLE and `InReady` rises on the first clock after reset deasserts.
- **IDLE**: `InReady`=1. On an accepted element (`InValid`&`InReady`): Acc←`InData`, Count←1. If `InLast` is set, go to DONE; otherwise go to ACCUM. The first element never goes through the adder.
- **ACCUM**: `InReady`=1. On an accepted element:
  - `Op1`←Acc, `Op2`←`InData`, `InputValid`←1 for exactly one cycle.
  - Count←Count+1, saturating at all-ones.
  - LastPend←`InLast`.
  - Go to WAIT.
- **WAIT**: `InReady`=0. `Op1`/`Op2` are held stable. On `ResultValid`: Acc←`Result`, then go to DONE if LastPend is set, otherwise to ACCUM.
- **DONE**: `SumValid`=1, `Sum`=Acc, `SumCount`=Count, `InReady`=0. Outputs are held until `SumReady`. On `SumValid`&`SumReady`, drop `SumValid` and go to IDLE.
- `ResultValid` outside WAIT is ignored and does not change Acc.
- `InValid` while `InReady`=0 is not consumed; the source must hold its data.
- Arithmetic: no float math is done here. Sign, zero and exponent handling belong entirely to the adder. Acc is a plain float register.
- An asynchronous reset assertion mid-stream aborts immediately: all state returns to reset values and any in-flight adder result is discarded.

## Timing
- Accept-to-`InputValid`: 1 cycle; `InputValid` is registered.
- One element's throughput is 1 cycle for the handshake plus the adder latency L plus 1 cycle to return to ACCUM. There is no back-to-back issue: at most one transaction is ever outstanding.
- A single-element stream gives `SumValid` on the cycle after acceptance.
- For an N-element stream, `SumValid` asserts 1 cycle after the final `ResultValid`.
- `ResultValid` in the same cycle as the watchdog expiry: the result wins and the timeout is not flagged.

## Configuration
- `FLOAT_ACC_TIMEOUT_EN` defined:
  - The watchdog counts cycles spent in WAIT.
  - On reaching `TIMEOUT_CYCLES` without `ResultValid`: `Error`←1 (sticky until reset), go to DONE, and present the partial Acc with Count.
  - `SumCount` then includes the element that did not complete.
- `FLOAT_ACC_TIMEOUT_EN` undefined: no counter, `Error` is tied to 0, and WAIT lasts indefinitely.

## Structure
- The `float` typedef (sign/exponent/mantissa) comes from the shared `floatingpoint` package.
- The state enum (IDLE, ACCUM, WAIT, DONE) is added to `floatingpoint` so benches can probe it.
- One sub-module, `float_acc_watchdog`: a load/clear/expire counter parameterised by `TIMEOUT_CYCLES`. It is instantiated only under `FLOAT_ACC_TIMEOUT_EN`.

## Test plan
The bench uses a behavioural adder model with configurable latency L.
- Single element 0x3F800000 (1.0) with `InLast` → `SumValid` next cycle, `Sum`=0x3F800000, `SumCount`=1, no `InputValid` pulse.
- Stream 1.0, 2.0 (0x40000000), 3.0 (0x40400000)+`InLast`, adder L=4:
  - Exactly two `InputValid` pulses: {0x3F800000,0x40000000}, then {0x40400000,0x40400000}.
  - `Sum`=0x40C00000 (6.0), `SumCount`=3.
- `SumReady` held low for 10 cycles → `Sum`/`SumCount` stable and `InReady`=0 throughout. Completes one cycle after `SumReady` rises.
- Spurious `ResultValid` with `Result`=0x7F800000 injected in ACCUM → ignored, final `Sum` unchanged.
- With `FLOAT_ACC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the adder never responds → `Error`=1 after 8 WAIT cycles and `SumValid` carries the partial Acc.
- `Reset` asserted low during WAIT, then released → all outputs at reset values and a fresh 2-element stream sums correctly.

Source files
------------

// File: rtl/floatingpoint_pkg.sv
// Shared floating-point package.
// Holds the IEEE-754 single-precision `float` layout used across the float
// datapath, plus the issuing-controller state encoding so that benches can
// probe the controller state by name.
package floatingpoint;

  // IEEE-754 binary32: 1 sign bit, 8 exponent bits, 23 mantissa bits.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  localparam float FLOAT_ZERO = '0;

  // States of float_accumulate_ctrl.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first element of a stream
    ACCUM = 2'd1,  // waiting for the next element to fold in
    WAIT  = 2'd2,  // one adder transaction outstanding
    DONE  = 2'd3   // total presented, waiting for SumReady
  } acc_state_e;

endpackage

// File: rtl/float_acc_watchdog.sv
// Watchdog counter for float_accumulate_ctrl.
// Counts cycles while count_i is high; clear_i returns the count to zero.
// expire_o is high in the cycle that would be the TIMEOUT_CYCLES-th counted
// cycle, so the owner can leave its wait state on that edge.
//
// Ports:
//   Clock    - clock, rising edge
//   Reset    - asynchronous active-low reset
//   clear_i  - restart the count from zero (has priority over count_i)
//   count_i  - count this cycle
//   expire_o - limit reached in this cycle
module float_acc_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = count_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/float_accumulate_ctrl.sv
// Issuing-side controller for the multi-cycle float adder.
// Accepts a stream of binary32 operands (valid/ready), folds each one into a
// running sum by issuing one Op1/Op2/InputValid transaction to the adder and
// waiting for its ResultValid pulse, then presents the total and the element
// count on a valid/ready result port. No float arithmetic is done here.
//
// Build option: define FLOAT_ACC_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES). Without it, Error is always 0 and WAIT never times out.
//
// Ports:
//   Clock, Reset            - clock; asynchronous active-low reset
//   InData/InValid/InLast   - operand stream input, InReady back-pressure
//   Op1/Op2/InputValid      - adder request (accumulator, new element, start)
//   Result/ResultValid      - adder response (one-cycle pulse)
//   Sum/SumCount/SumValid   - final total and element count, SumReady accepts
//   Error                   - sticky watchdog flag
module float_accumulate_ctrl
  import floatingpoint::*;
#(
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  input  float               InData,
  input  logic               InValid,
  input  logic               InLast,
  output logic               InReady,
  output float               Op1,
  output float               Op2,
  output logic               InputValid,
  input  float               Result,
  input  logic               ResultValid,
  output float               Sum,
  output logic [COUNT_W-1:0] SumCount,
  output logic               SumValid,
  input  logic               SumReady,
  output logic               Error
);

  acc_state_e         state_q, state_d;
  float               acc_q, acc_d;
  float               op1_q, op1_d;
  float               op2_q, op2_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               last_pend_q, last_pend_d;
  logic               in_ready_q, in_ready_d;
  logic               input_valid_q, input_valid_d;
  logic               error_q, error_d;
  logic               in_fire;
  logic               timeout;

  assign in_fire = InValid & in_ready_q;

`ifdef FLOAT_ACC_TIMEOUT_EN
  float_acc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear_i (state_q != WAIT),
    .count_i (state_q == WAIT),
    .expire_o(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d       = state_q;
    acc_d         = acc_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    count_d       = count_q;
    last_pend_d   = last_pend_q;
    input_valid_d = 1'b0;
    error_d       = error_q;

    unique case (state_q)
      IDLE: begin
        // The first element seeds the accumulator without an adder pass.
        if (in_fire) begin
          acc_d   = InData;
          count_d = COUNT_W'(1);
          state_d = InLast ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          op1_d         = acc_q;
          op2_d         = InData;
          input_valid_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + COUNT_W'(1);
          end
          last_pend_d   = InLast;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the expiry cycle takes priority over timeout.
        if (ResultValid) begin
          acc_d   = Result;
          state_d = last_pend_q ? DONE : ACCUM;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (SumReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // InReady is registered so it stays low until the first clock after reset.
    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      acc_q         <= FLOAT_ZERO;
      op1_q         <= FLOAT_ZERO;
      op2_q         <= FLOAT_ZERO;
      count_q       <= '0;
      last_pend_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      input_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q       <= state_d;
      acc_q         <= acc_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      count_q       <= count_d;
      last_pend_q   <= last_pend_d;
      in_ready_q    <= in_ready_d;
      input_valid_q <= input_valid_d;
      error_q       <= error_d;
    end
  end

  assign InReady    = in_ready_q;
  assign Op1        = op1_q;
  assign Op2        = op2_q;
  assign InputValid = input_valid_q;
  assign Sum        = acc_q;
  assign SumCount   = count_q;
  assign SumValid   = (state_q == DONE);
  assign Error      = error_q;

endmodule
